if_id_hazard: RTL
=================

IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles IF/ID is squashed after a taken branch; legal range 1..7.
REQ-002 Port: clock  input  1  sole clock; all state updates on posedge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: instrIn  input  32  fetched instruction from IF.
REQ-005 Port: pcIn  input  32  PC+4 of fetched instruction.
REQ-006 Port: fetchValid  input  1  instrIn/pcIn valid this cycle.
REQ-007 Port: idExMemRead  input  1  memory-read control bit currently held in ID/EX.
REQ-008 Port: idExRegisterTarget  input  5  rt field currently held in ID/EX.
REQ-009 Port: branchTaken  input  1  taken-branch pulse from EX/MEM.
REQ-010 Port: instrOut  output  32  instruction presented to ID.
REQ-011 Port: pcOut  output  32  PC+4 presented to ID.
REQ-012 Port: validOut  output  1  instrOut holds a real instruction.
REQ-013 Port: pcWrite  output  1  PC/fetch may advance; 0 holds PC.
REQ-014 Port: bubble  output  1  ID must drive zero control (writeBack/memory/EX) into ID/EX this cycle.
REQ-015 Port: stallCount  output  16  saturating count of load-use stall cycles.

Function
REQ-016 Hazard (combinational): loadUse = validOut & idExMemRead & (idExRegisterTarget != 0) & (idExRegisterTarget == instrOut[25:21] | idExRegisterTarget == instrOut[20:16]).
REQ-017 pcWrite = ~loadUse & ~branchTaken in RUN; pcWrite = 1 in FLUSH; bubble = loadUse | (state == FLUSH) | branchTaken.
REQ-018 FSM states: RUN, FLUSH; flushCnt 3-bit counter.
REQ-019 RUN, branchTaken=1: next state FLUSH, flushCnt <= FLUSH_CYCLES-1, register loads NOP (32'h0), validOut <= 0, pcOut holds.
REQ-020 RUN, branchTaken=0, loadUse=1: instrOut/pcOut/validOut hold; stallCount += 1 unless 16'hFFFF.
REQ-021 RUN, no branch, no loadUse, fetchValid=1: instrOut<=instrIn, pcOut<=pcIn, validOut<=1, latency one cycle.
REQ-022 RUN, no branch, no loadUse, fetchValid=0: instrOut<=0, validOut<=0, pcOut holds.
REQ-023 FLUSH: instrOut<=0, validOut<=0 each cycle; flushCnt==0 -> RUN next cycle, else flushCnt decrements.
REQ-024 branchTaken=1 during FLUSH restarts flushCnt at FLUSH_CYCLES-1.
REQ-025 Priority: reset > branchTaken > loadUse > fetchValid.
REQ-026 loadUse never asserted while validOut=0 (bubbles never stall).
REQ-027 stallCount saturates at 16'hFFFF, never wraps.

Reset
REQ-028 reset_n low asynchronously forces instrOut=0, pcOut=0, validOut=0, state=RUN, flushCnt=0, stallCount=0.
REQ-029 Reset asserted mid-FLUSH or mid-stall aborts it; first posedge after release behaves as RUN with empty register.
REQ-030 During reset pcWrite=1, bubble=0 (validOut=0 implies no loadUse).

Structure
REQ-031 Shared package pipeline_pkg holds NOP constant 32'h0, rs/rt field bit ranges, and the RUN/FLUSH state encoding.
REQ-032 One sub-module, hazard_detect, holds the REQ-016 comparator; the FSM, register and counters stay in if_id_hazard.

Verification
REQ-033 Reset: reset_n=0 mid-run -> all outputs zero immediately, no clock edge needed; stallCount=0.
REQ-034 Pass-through: fetchValid=1, instrIn=32'h8C220004, pcIn=32'h00000010 -> next cycle instrOut=32'h8C220004, pcOut=32'h10, validOut=1.
REQ-035 Load-use: instrOut=32'h00432020 (rs=2), idExMemRead=1, idExRegisterTarget=2 -> pcWrite=0, bubble=1, instrOut held one cycle, stallCount=1; target=0 -> no stall.
REQ-036 Branch flush: branchTaken pulse with FLUSH_CYCLES=2 -> validOut=0 for exactly 3 cycles (entry + 2), then first new instrIn captured.
REQ-037 Simultaneous: branchTaken=1 and loadUse=1 same cycle -> flush wins, stallCount unchanged, pcWrite=0 that cycle.
REQ-038 Saturation: force 65540 stall cycles -> stallCount stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the IF/ID stage of the classic five-stage pipeline:
// the NOP encoding used to squash the stage, the bit positions of the rs/rt
// register fields, and the encoding of the IF/ID hazard controller states.
// No ports; imported by if_id_hazard and hazard_detect.
package pipeline_pkg;

  // All-zero word decodes as sll $0,$0,0, so it has no architectural effect
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Source register fields of an R/I-type instruction word
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  // RUN: normal fetch/stall operation; FLUSH: squashing after a taken branch
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazardState_t;

  function automatic logic [4:0] rsField(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] rtField(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Load-use comparator. Flags the case where the instruction sitting in IF/ID
// reads a register that the load currently in ID/EX has not yet written.
// Ports:
//   valid              - IF/ID holds a real instruction (bubbles never stall)
//   idExMemRead        - the instruction in ID/EX is a load
//   idExRegisterTarget - destination (rt) of the instruction in ID/EX
//   rs, rt             - source register fields of the IF/ID instruction
//   loadUse            - a one-cycle stall is required
module hazard_detect (
  input  logic       valid,
  input  logic       idExMemRead,
  input  logic [4:0] idExRegisterTarget,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       loadUse
);

  // $zero is never really written, so a load targeting it cannot cause a hazard
  assign loadUse = valid & idExMemRead & (idExRegisterTarget != 5'd0) &
                   ((idExRegisterTarget == rs) | (idExRegisterTarget == rt));

endmodule

// File: rtl/if_id_hazard.sv
// if_id_hazard
// IF/ID pipeline register with its hazard controller. Stalls the front end
// for load-use hazards, squashes IF/ID for FLUSH_CYCLES cycles after a taken
// branch, and counts load-use stall cycles (saturating).
// Parameter:
//   FLUSH_CYCLES       - cycles squashed after the branch entry cycle (1..7)
// Ports:
//   clock, reset_n     - clock (posedge) and asynchronous active-low reset
//   instrIn, pcIn      - fetched instruction and its PC+4
//   fetchValid         - instrIn/pcIn are valid this cycle
//   idExMemRead        - ID/EX holds a load
//   idExRegisterTarget - rt field held in ID/EX
//   branchTaken        - taken-branch pulse from EX/MEM
//   instrOut, pcOut    - instruction and PC+4 presented to ID
//   validOut           - instrOut holds a real instruction
//   pcWrite            - PC/fetch may advance
//   bubble             - ID must inject zero control into ID/EX
//   stallCount         - saturating count of load-use stall cycles
module if_id_hazard
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  input  logic        fetchValid,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRegisterTarget,
  input  logic        branchTaken,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        validOut,
  output logic        pcWrite,
  output logic        bubble,
  output logic [15:0] stallCount
);

  // The branch entry cycle is squashed on its own, so the counter covers the rest
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  hazardState_t state, stateNext;
  logic [2:0]   flushCnt, flushCntNext;
  logic [31:0]  instrNext, pcNext;
  logic         validNext;
  logic [15:0]  stallNext;
  logic         loadUse;

  hazard_detect uHazardDetect (
    .valid              (validOut),
    .idExMemRead        (idExMemRead),
    .idExRegisterTarget (idExRegisterTarget),
    .rs                 (rsField(instrOut)),
    .rt                 (rtField(instrOut)),
    .loadUse            (loadUse)
  );

  // Next-state, register-load and control decisions.
  // Priority within RUN is branchTaken > loadUse > fetchValid.
  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    instrNext    = instrOut;
    pcNext       = pcOut;
    validNext    = validOut;
    stallNext    = stallCount;
    pcWrite      = 1'b1;
    bubble       = 1'b0;

    case (state)
      RUN: begin
        if (branchTaken) begin
          stateNext    = FLUSH;
          flushCntNext = FLUSH_RELOAD;
          instrNext    = NOP;
          validNext    = 1'b0;
          pcWrite      = 1'b0;
          bubble       = 1'b1;
        end else if (loadUse) begin
          pcWrite = 1'b0;
          bubble  = 1'b1;
          if (stallCount != 16'hFFFF) begin
            stallNext = stallCount + 16'd1;
          end
        end else if (fetchValid) begin
          instrNext = instrIn;
          pcNext    = pcIn;
          validNext = 1'b1;
        end else begin
          instrNext = NOP;
          validNext = 1'b0;
        end
      end

      FLUSH: begin
        instrNext = NOP;
        validNext = 1'b0;
        bubble    = 1'b1;
        // A second taken branch while flushing restarts the squash window
        if (branchTaken) begin
          flushCntNext = FLUSH_RELOAD;
        end else if (flushCnt == 3'd0) begin
          stateNext = RUN;
        end else begin
          flushCntNext = flushCnt - 3'd1;
        end
      end

      default: begin
        stateNext = RUN;
      end
    endcase

    // While held in reset the front end must look idle regardless of branchTaken
    if (!reset_n) begin
      pcWrite = 1'b1;
      bubble  = 1'b0;
    end
  end

  // IF/ID register, controller state and stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      flushCnt   <= 3'd0;
      instrOut   <= NOP;
      pcOut      <= 32'h0;
      validOut   <= 1'b0;
      stallCount <= 16'h0;
    end else begin
      state      <= stateNext;
      flushCnt   <= flushCntNext;
      instrOut   <= instrNext;
      pcOut      <= pcNext;
      validOut   <= validNext;
      stallCount <= stallNext;
    end
  end

endmodule
